// File: rtl/lshifup_rx_filter.sv
// Receive-side conditioner behind the up level shifter: synchronises A, rejects glitches with a
// consecutive-sample filter, and reports accepted edges as pulses and as a one-entry event register.
module lshifup_rx_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic CLK,
  input  logic RN,
  input  logic A,
  input  logic EN,
  output logic Y,
  output logic RISE,
  output logic FALL,
  output logic EVT_VALID,
  output logic EVT_EDGE,
  input  logic EVT_READY,
  output logic OVF,
  input  logic CLR_OVF
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic y_q, y_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic evt_valid_q, evt_valid_d;
  logic evt_edge_q, evt_edge_d;
  logic ovf_q, ovf_d;

  logic s;
  logic mismatch;
  logic accept;
  logic push;
  logic drop;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], A};
    s      = sync_q[SYNC_STAGES-1];
  end

  // Any break in the mismatch run (or EN low) restarts the count from zero.
  always_comb begin
    mismatch = EN && (s != y_q);
    accept   = mismatch && (cnt_q == CNT_LAST);
    cnt_d    = (mismatch && !accept) ? cnt_q + CNT_W'(1) : '0;
    y_d      = accept ? s : y_q;
    rise_d   = accept && s;
    fall_d   = accept && !s;
  end

  // A pop in the same cycle as a push frees the slot, so the new edge is kept.
  always_comb begin
    push        = accept && (!evt_valid_q || EVT_READY);
    drop        = accept && evt_valid_q && !EVT_READY;
    evt_valid_d = evt_valid_q;
    evt_edge_d  = evt_edge_q;
    if (push) begin
      evt_valid_d = 1'b1;
      evt_edge_d  = s;
    end else if (evt_valid_q && EVT_READY) begin
      evt_valid_d = 1'b0;
    end
    ovf_d = drop || (ovf_q && !CLR_OVF);
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      y_q         <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_edge_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      evt_valid_q <= evt_valid_d;
      evt_edge_q  <= evt_edge_d;
      ovf_q       <= ovf_d;
    end
  end

  assign Y         = y_q;
  assign RISE      = rise_q;
  assign FALL      = fall_q;
  assign EVT_VALID = evt_valid_q;
  assign EVT_EDGE  = evt_edge_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_lshifup_rx_filter.sv
// Scenario bench for lshifup_rx_filter: directed scenarios plus randomized traffic, each checked
// against a behavioural model built from a sample-delay queue and a mismatch run length.
module tb_lshifup_rx_filter;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int CW   = 8;

  logic CLK = 1'b0;
  logic RN, A, EN, EVT_READY, CLR_OVF;
  logic Y, RISE, FALL, EVT_VALID, EVT_EDGE, OVF;

  int n_vec = 0;
  int n_err = 0;

  lshifup_rx_filter #(.SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .CNT_W(CW)) dut (
    .CLK(CLK), .RN(RN), .A(A), .EN(EN), .Y(Y), .RISE(RISE), .FALL(FALL),
    .EVT_VALID(EVT_VALID), .EVT_EDGE(EVT_EDGE), .EVT_READY(EVT_READY),
    .OVF(OVF), .CLR_OVF(CLR_OVF)
  );

  always #5 CLK = ~CLK;

  // Behavioural model state
  bit m_hist [SYNC];
  bit m_y, m_rise, m_fall, m_vld, m_edge, m_ovf;
  int m_run;

  logic [5:0] dut_vec;
  assign dut_vec = {Y, RISE, FALL, EVT_VALID, EVT_EDGE, OVF};

  function automatic logic [5:0] model_vec();
    return {m_y, m_rise, m_fall, m_vld, m_edge, m_ovf};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
    m_y = 0; m_rise = 0; m_fall = 0; m_vld = 0; m_edge = 0; m_ovf = 0;
    m_run = 0;
  endtask

  // One clock edge; the model consumes the inputs that the DUT saw at that edge.
  task automatic tick();
    bit s, acc, drop;
    @(posedge CLK);
    if (!RN) begin
      model_reset();
    end else begin
      s = m_hist[SYNC-1];
      acc = 0;
      if (EN && s != m_y) begin
        m_run++;
        if (m_run == FILT) begin
          acc = 1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_rise = acc && s;
      m_fall = acc && !s;
      if (acc) m_y = s;
      drop = acc && m_vld && !EVT_READY;
      if (acc && !drop) begin
        m_vld = 1;
        m_edge = m_y;
      end else if (m_vld && EVT_READY) begin
        m_vld = 0;
      end
      m_ovf = drop ? 1'b1 : (CLR_OVF ? 1'b0 : m_ovf);
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = A;
    end
    #1;
  endtask

  task automatic do_reset(input bit a_val);
    RN = 0; A = a_val; EN = 1; EVT_READY = 1; CLR_OVF = 0;
    tick();
    RN = 1;
  endtask

  task automatic test_reset();
    RN = 0; A = 1; EN = 1; EVT_READY = 0; CLR_OVF = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (dut_vec !== 6'b0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: outputs=%b expected=%b", i, dut_vec, 6'b0);
      end
    end
    RN = 1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL reset_release_edge%0d: outputs=%b expected=%b", e, dut_vec, model_vec());
      end
    end
    n_vec++;
    if ({Y, RISE, FALL, EVT_VALID, EVT_EDGE} !== 5'b11011) begin
      n_err++;
      $display("FAIL reset_rise_at_6: Y/RISE/FALL/V/E=%b expected=11011",
               {Y, RISE, FALL, EVT_VALID, EVT_EDGE});
    end
    tick();
    n_vec++;
    if (RISE !== 1'b0 || Y !== 1'b1) begin
      n_err++;
      $display("FAIL reset_rise_single: RISE=%b Y=%b expected RISE=0 Y=1", RISE, Y);
    end
  endtask

  task automatic test_glitch();
    int rises, falls, yhigh, evts;
    do_reset(1'b0);
    tick(); tick();
    A = 1;
    for (int i = 0; i < 3; i++) tick();
    A = 0;
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rises += RISE;
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL glitch_model[%0d]: outputs=%b expected=%b", i, dut_vec, model_vec());
      end
    end
    n_vec++;
    if (Y !== 1'b0 || rises != 0 || EVT_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_reject: Y=%b rises=%0d V=%b expected 0/0/0", Y, rises, EVT_VALID);
    end
    A = 1;
    rises = 0; falls = 0; yhigh = 0; evts = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) A = 0;
      tick();
      rises += RISE; falls += FALL; yhigh += Y; evts += EVT_VALID;
    end
    n_vec++;
    if (rises != 1 || falls != 1 || yhigh != 4 || evts != 2) begin
      n_err++;
      $display("FAIL pulse_accept: rises=%0d falls=%0d yhigh=%0d evt_cycles=%0d expected 1/1/4/2",
               rises, falls, yhigh, evts);
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    EVT_READY = 0;
    A = 1;
    for (int i = 0; i < 8; i++) tick();
    n_vec++;
    if ({Y, EVT_VALID, EVT_EDGE, OVF} !== 4'b1110) begin
      n_err++;
      $display("FAIL bp_first_held: Y/V/E/OVF=%b expected=1110", {Y, EVT_VALID, EVT_EDGE, OVF});
    end
    A = 0;
    for (int i = 0; i < 8; i++) tick();
    n_vec++;
    if ({Y, EVT_VALID, EVT_EDGE, OVF} !== 4'b0111 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL bp_second_dropped: Y/V/E/OVF=%b expected=0111", {Y, EVT_VALID, EVT_EDGE, OVF});
    end
    CLR_OVF = 1;
    tick();
    CLR_OVF = 0;
    n_vec++;
    if (OVF !== 1'b0 || EVT_VALID !== 1'b1 || EVT_EDGE !== 1'b1) begin
      n_err++;
      $display("FAIL bp_clr_ovf: OVF=%b V=%b E=%b expected 0/1/1", OVF, EVT_VALID, EVT_EDGE);
    end
  endtask

  task automatic test_pop_push();
    do_reset(1'b0);
    EVT_READY = 0;
    A = 1;
    for (int i = 0; i < 8; i++) tick();
    A = 0;
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if ({Y, EVT_VALID, EVT_EDGE} !== 3'b111) begin
      n_err++;
      $display("FAIL poppush_setup: Y/V/E=%b expected=111", {Y, EVT_VALID, EVT_EDGE});
    end
    EVT_READY = 1;
    tick();
    n_vec++;
    if ({Y, FALL, EVT_VALID, EVT_EDGE, OVF} !== 5'b01100) begin
      n_err++;
      $display("FAIL popush_lossless: Y/FALL/V/E/OVF=%b expected=01100",
               {Y, FALL, EVT_VALID, EVT_EDGE, OVF});
    end
    tick();
    n_vec++;
    if (EVT_VALID !== 1'b0 || FALL !== 1'b0) begin
      n_err++;
      $display("FAIL popush_drain: V=%b FALL=%b expected 0/0", EVT_VALID, FALL);
    end
  endtask

  task automatic test_en_gating();
    int pulses;
    do_reset(1'b0);
    tick(); tick();
    EN = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      A = (i % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      pulses += RISE + FALL + EVT_VALID + Y;
    end
    A = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += RISE + FALL + EVT_VALID + Y;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL en_gated: activity=%0d expected=0", pulses);
    end
    EN = 1;
    for (int e = 1; e <= FILT; e++) begin
      tick();
      n_vec++;
      if (Y !== (e == FILT) || RISE !== (e == FILT)) begin
        n_err++;
        $display("FAIL en_resume_edge%0d: Y=%b RISE=%b expected %0b", e, Y, RISE, e == FILT);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    EVT_READY = 0;
    A = 1;
    for (int i = 0; i < 8; i++) tick();
    A = 0;
    for (int i = 0; i < 4; i++) tick();
    n_vec++;
    if (m_run != 2 || {Y, EVT_VALID} !== 2'b11) begin
      n_err++;
      $display("FAIL midrst_setup: Y/V=%b run=%0d expected 11 and 2", {Y, EVT_VALID}, m_run);
    end
    RN = 0;
    tick();
    n_vec++;
    if (dut_vec !== 6'b0) begin
      n_err++;
      $display("FAIL midrst_clear: outputs=%b expected=%b", dut_vec, 6'b0);
    end
    RN = 1;
    A = 1;
    for (int e = 1; e <= SYNC + FILT; e++) begin
      tick();
      n_vec++;
      if (Y !== (e == SYNC + FILT)) begin
        n_err++;
        $display("FAIL midrst_restart_edge%0d: Y=%b expected=%0b", e, Y, e == SYNC + FILT);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        A = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 7);
      end
      hold--;
      EN        = ($urandom_range(0, 9) != 0);
      EVT_READY = ($urandom_range(0, 3) == 0);
      CLR_OVF   = ($urandom_range(0, 11) == 0);
      RN        = ($urandom_range(0, 79) != 0);
      tick();
      n_vec++;
      if (dut_vec !== model_vec() || (RISE && FALL)) begin
        n_err++;
        $display("FAIL random[%0d]: outputs=%b expected=%b", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    RN = 0; A = 0; EN = 0; EVT_READY = 0; CLR_OVF = 0;
    test_reset();
    test_glitch();
    test_backpressure();
    test_pop_push();
    test_en_gating();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
